// File: rtl/seq_feeder_pkg.sv
// Shared types and defaults for the systolic-array sequence feeder.
// Build option: SEQ_FEEDER_CHK_EN enables ASCII legality checking and the o_err flag.
package seq_feeder_pkg;

  localparam int PE_NUM_DEF  = 64;
  localparam int MAX_REF_DEF = 200;
  localparam int CNT_W_DEF   = 9;

  typedef enum logic [1:0] {
    BASE_A = 2'd0,
    BASE_C = 2'd1,
    BASE_G = 2'd2,
    BASE_T = 2'd3
  } base_e;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_Q,
    LOAD_R,
    STREAM,
    DRAIN
  } state_e;

  // A=x00, C=x01, G=x11, T=x10 in bits [2:1] for both cases of ASCII.
  function automatic logic [1:0] cheap_enc(input logic [7:0] c);
    return {c[2], c[2] ^ c[1]};
  endfunction

endpackage

// File: rtl/seq_feeder_if.sv
// Character stream handshake into the sequence feeder.
// Build option: SEQ_FEEDER_CHK_EN (no effect on this interface).
interface seq_feeder_if;
  logic       valid;
  logic       ready;
  logic [7:0] ch;
  logic       last;

  modport master (output valid, ch, last, input ready);
  modport slave  (input valid, ch, last, output ready);
endinterface

// File: rtl/seq_feeder_ascii_base_enc.sv
// ASCII nucleotide to 2-bit code; illegal flag is only meaningful when
// SEQ_FEEDER_CHK_EN is defined, otherwise a cheap bit map is used.
module ascii_base_enc
  import seq_feeder_pkg::*;
(
  input  logic [7:0] i_char,
  output logic [1:0] o_code,
  output logic       o_illegal
);

`ifdef SEQ_FEEDER_CHK_EN
  always_comb begin
    o_code    = BASE_A;
    o_illegal = 1'b0;
    case (i_char)
      "A", "a": o_code = BASE_A;
      "C", "c": o_code = BASE_C;
      "G", "g": o_code = BASE_G;
      "T", "t": o_code = BASE_T;
      default:  o_illegal = 1'b1;
    endcase
  end
`else
  assign o_code    = cheap_enc(i_char);
  assign o_illegal = 1'b0;
`endif

endmodule

// File: rtl/seq_feeder.sv
// Loads query/reference bases, then streams the reference to the PE array and drains it.
// Build option: SEQ_FEEDER_CHK_EN adds illegal-char and overflow reporting on o_err.
module seq_feeder
  import seq_feeder_pkg::*;
#(
  parameter int PE_NUM  = PE_NUM_DEF,
  parameter int MAX_REF = MAX_REF_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  seq_feeder_if.slave           s_in,
  output logic [2*PE_NUM-1:0]   o_B,
  output logic [1:0]            o_A,
  output logic                  o_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [CNT_W-1:0]      o_ref_len,
  output logic                  o_err
);

  localparam int QW = (PE_NUM  > 1) ? $clog2(PE_NUM)  : 1;
  localparam int RW = (MAX_REF > 1) ? $clog2(MAX_REF) : 1;
  localparam logic [CNT_W-1:0] C_QMAX = CNT_W'(PE_NUM);
  localparam logic [CNT_W-1:0] C_RMAX = CNT_W'(MAX_REF);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  state_e           r_state;
  logic [CNT_W-1:0] r_q, r_r, r_k, r_d, r_len;
  logic [1:0]       r_qry [PE_NUM];
  logic [1:0]       r_ram [MAX_REF];
  logic             r_start, r_done, r_busy;

  logic       w_xfer, w_q_full, w_r_full, w_illegal;
  logic [1:0] w_code;

  ascii_base_enc u_enc (
    .i_char    (s_in.ch),
    .o_code    (w_code),
    .o_illegal (w_illegal)
  );

  assign s_in.ready = (r_state == IDLE) || (r_state == LOAD_Q) || (r_state == LOAD_R);
  assign w_xfer     = s_in.valid & s_in.ready;
  assign w_q_full   = (r_q == C_QMAX);
  assign w_r_full   = (r_r == C_RMAX);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_r     <= '0;
      r_k     <= '0;
      r_d     <= '0;
      r_len   <= '0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      for (int i = 0; i < PE_NUM; i++) r_qry[i] <= 2'b00;
    end else begin
      r_start <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: if (w_xfer) begin
          // A new job starts from a clean query word so short queries pad with A.
          for (int i = 1; i < PE_NUM; i++) r_qry[i] <= 2'b00;
          r_qry[0] <= w_code;
          r_q      <= C_ONE;
          r_r      <= '0;
          r_busy   <= 1'b1;
          r_state  <= s_in.last ? LOAD_R : LOAD_Q;
        end
        LOAD_Q: if (w_xfer) begin
          if (!w_q_full) begin
            r_qry[r_q[QW-1:0]] <= w_code;
            r_q                <= r_q + C_ONE;
          end
          if (s_in.last) r_state <= LOAD_R;
        end
        LOAD_R: if (w_xfer) begin
          if (!w_r_full) r_r <= r_r + C_ONE;
          if (s_in.last) begin
            r_len   <= w_r_full ? r_r : r_r + C_ONE;
            r_k     <= '0;
            r_start <= 1'b1;
            r_state <= STREAM;
          end
        end
        STREAM: begin
          if (r_k == r_len - C_ONE) begin
            r_d     <= '0;
            r_state <= DRAIN;
          end else begin
            r_k <= r_k + C_ONE;
          end
        end
        DRAIN: begin
          // d = 0..PE_NUM-1 flush the array; d = PE_NUM is the o_done cycle.
          if (r_d == C_QMAX) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_d <= r_d + C_ONE;
            if (r_d == C_QMAX - C_ONE) r_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (r_state == LOAD_R && w_xfer && !w_r_full) r_ram[r_r[RW-1:0]] <= w_code;
  end

  assign o_A       = (r_state == STREAM) ? r_ram[r_k[RW-1:0]] : 2'b00;
  assign o_start   = r_start;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_ref_len = r_len;

  generate
    for (genvar gi = 0; gi < PE_NUM; gi++) begin : g_bword
      assign o_B[2*gi +: 2] = r_qry[gi];
    end
  endgenerate

`ifdef SEQ_FEEDER_CHK_EN
  logic r_err;
  logic w_ovf;
  assign w_ovf = ((r_state == LOAD_Q) && w_q_full) || ((r_state == LOAD_R) && w_r_full);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_err <= 1'b0;
    end else if (w_xfer) begin
      if (r_state == IDLE)          r_err <= w_illegal;
      else if (w_illegal || w_ovf)  r_err <= 1'b1;
    end
  end
  assign o_err = r_err;
`else
  logic w_unused;
  assign w_unused = &{1'b0, w_illegal};
  assign o_err    = 1'b0;
`endif

endmodule
